// File: rtl/pll_seq_pkg.sv
// Shared types and default parameter values for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int SYNC_STAGES_DEF    = 2;
  localparam int STABLE_CYCLES_DEF  = 1024;
  localparam int HOLD_CYCLES_DEF    = 16;
  localparam int LOSS_CNT_W_DEF     = 8;
  localparam int TIMEOUT_CYCLES_DEF = 65536;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Multi-stage single-bit synchroniser for the raw PLL lock flag, async active-low clear.
module lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift chain; only the last stage is safe to use downstream.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Qualifies the PLL lock flag and produces a clean downstream reset.
// Optional WAIT_LOCK/STABLE timeout flag enabled by defining LOCK_TIMEOUT_EN.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES  = STABLE_CYCLES_DEF,
  parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int LOSS_CNT_W     = LOSS_CNT_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  output logic                  rst_out_n,
  output logic                  ready,
  output logic                  lock_lost_pulse,
  output logic [LOSS_CNT_W-1:0] loss_count,
  output logic                  pll_timeout
);

`ifdef LOCK_TIMEOUT_EN
  localparam int CNT_MAX = max_int(max_int(STABLE_CYCLES, HOLD_CYCLES), TIMEOUT_CYCLES);
`else
  localparam int CNT_MAX = max_int(STABLE_CYCLES, HOLD_CYCLES);
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  seq_state_e       state_r;
  seq_state_e       next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] next_cnt_s;
  logic             lock_s;
  logic             lost_s;

  lock_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .d        (pll_locked),
    .q        (lock_s)
  );

  // Next-state and qualification counter; the cycle lock_s is first seen counts as stable cycle 1.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    lost_s       = 1'b0;
    case (state_r)
      WAIT_LOCK: begin
        next_cnt_s = '0;
        if (!lock_s) begin
          next_state_s = WAIT_LOCK;
        end else if (STABLE_CYCLES == 1) begin
          next_state_s = HOLD;
        end else begin
          next_state_s = STABLE;
          next_cnt_s   = CNT_W'(1);
        end
      end
      STABLE: begin
        if (!lock_s) begin
          next_state_s = WAIT_LOCK;
          next_cnt_s   = '0;
        end else if (cnt_r == CNT_W'(STABLE_CYCLES - 1)) begin
          next_state_s = HOLD;
          next_cnt_s   = '0;
        end else begin
          next_cnt_s = cnt_r + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!lock_s) begin
          next_state_s = WAIT_LOCK;
          next_cnt_s   = '0;
        end else if (cnt_r == CNT_W'(HOLD_CYCLES - 1)) begin
          next_state_s = RUN;
          next_cnt_s   = '0;
        end else begin
          next_cnt_s = cnt_r + CNT_W'(1);
        end
      end
      RUN: begin
        next_cnt_s = '0;
        if (!lock_s) begin
          next_state_s = WAIT_LOCK;
          lost_s       = 1'b1;
        end else begin
          next_state_s = RUN;
        end
      end
      default: begin
        next_state_s = WAIT_LOCK;
        next_cnt_s   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; rst_out_n/ready track the next state so they move with RUN.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= WAIT_LOCK;
      cnt_r           <= '0;
      rst_out_n       <= 1'b0;
      ready           <= 1'b0;
      lock_lost_pulse <= 1'b0;
      loss_count      <= '0;
    end else begin
      state_r         <= next_state_s;
      cnt_r           <= next_cnt_s;
      rst_out_n       <= (next_state_s == RUN);
      ready           <= (next_state_s == RUN);
      lock_lost_pulse <= lost_s;
      if (lost_s && (loss_count != {LOSS_CNT_W{1'b1}})) begin
        loss_count <= loss_count + LOSS_CNT_W'(1);
      end else begin
        loss_count <= loss_count;
      end
    end
  end

`ifdef LOCK_TIMEOUT_EN
  logic [CNT_W-1:0] tmo_cnt_r;
  logic             tmo_r;
  logic             tmo_run_s;

  assign tmo_run_s = (state_r == WAIT_LOCK) || (state_r == STABLE);

  // Sticky timeout: counts while unqualified, clears on entry to HOLD, flag held until reset_n.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_r <= '0;
      tmo_r     <= 1'b0;
    end else begin
      if (tmo_run_s && (next_state_s == HOLD)) begin
        tmo_cnt_r <= '0;
      end else if (tmo_run_s && (tmo_cnt_r != CNT_W'(TIMEOUT_CYCLES))) begin
        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end
      if (tmo_run_s && (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1))) begin
        tmo_r <= 1'b1;
      end else begin
        tmo_r <= tmo_r;
      end
    end
  end

  assign pll_timeout = tmo_r;
`else
  assign pll_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with SYNC=2, STABLE=8, HOLD=4, LOSS_CNT_W=2 (14-edge lock latency).
module tb_pll_lock_sequencer;

  localparam int LW = 2;

  logic          clock_in;
  logic          reset_n;
  logic          pll_locked;
  logic          rst_out_n;
  logic          ready;
  logic          lock_lost_pulse;
  logic [LW-1:0] loss_count;
  logic          pll_timeout;

  int total  = 0;
  int bad    = 0;
  int pulses = 0;

  pll_lock_sequencer #(
    .SYNC_STAGES    (2),
    .STABLE_CYCLES  (8),
    .HOLD_CYCLES    (4),
    .LOSS_CNT_W     (LW),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clock_in        (clock_in),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .rst_out_n       (rst_out_n),
    .ready           (ready),
    .lock_lost_pulse (lock_lost_pulse),
    .loss_count      (loss_count),
    .pll_timeout     (pll_timeout)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
    if (lock_lost_pulse === 1'b1) pulses++;
  endtask

  // Raise lock; reset must stay asserted for 13 edges and release on the 14th.
  task automatic run_lock(input string tag);
    pll_locked = 1'b1;
    for (int i = 1; i < 14; i++) begin
      tick();
      check({tag, "_rst_held"}, {31'd0, rst_out_n}, 32'd0);
      check({tag, "_no_pulse"}, {31'd0, lock_lost_pulse}, 32'd0);
    end
    tick();
    check({tag, "_rst_release"}, {31'd0, rst_out_n}, 32'd1);
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
  endtask

  // Drop lock from RUN; reset falls two edges after the first sampling edge.
  task automatic drop_lock(input string tag, input int exp_cnt);
    pll_locked = 1'b0;
    tick();
    check({tag, "_edge1_rst"}, {31'd0, rst_out_n}, 32'd1);
    tick();
    check({tag, "_edge2_rst"}, {31'd0, rst_out_n}, 32'd1);
    tick();
    check({tag, "_edge3_rst"}, {31'd0, rst_out_n}, 32'd0);
    check({tag, "_edge3_ready"}, {31'd0, ready}, 32'd0);
    check({tag, "_pulse"}, {31'd0, lock_lost_pulse}, 32'd1);
    check({tag, "_count"}, {30'd0, loss_count}, exp_cnt);
    tick();
    check({tag, "_pulse_end"}, {31'd0, lock_lost_pulse}, 32'd0);
    check({tag, "_count_hold"}, {30'd0, loss_count}, exp_cnt);
  endtask

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    repeat (3) @(posedge clock_in);
    #1;
    check("reset_rst_out_n", {31'd0, rst_out_n}, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_pulse", {31'd0, lock_lost_pulse}, 32'd0);
    check("reset_loss_count", {30'd0, loss_count}, 32'd0);
    check("reset_timeout", {31'd0, pll_timeout}, 32'd0);
    reset_n = 1'b1;
    repeat (3) tick();
    check("idle_unlocked", {31'd0, rst_out_n}, 32'd0);

    run_lock("clean");
    check("clean_no_pulses", pulses, 32'd0);
    drop_lock("loss1", 1);

    // Glitch during STABLE: 5 high, 1 low, then high again.
    pll_locked = 1'b1;
    repeat (5) tick();
    pll_locked = 1'b0;
    tick();
    check("glitch_rst_low", {31'd0, rst_out_n}, 32'd0);
    run_lock("glitch");
    check("glitch_count", {30'd0, loss_count}, 32'd1);
    check("glitch_pulses", pulses, 32'd1);

    drop_lock("loss2", 2);
    run_lock("relock2");
    drop_lock("loss3", 3);
    run_lock("relock3");
    drop_lock("loss4_sat", 3);
    run_lock("relock4");
    drop_lock("loss5_sat", 3);
    check("sat_pulses", pulses, 32'd5);

    // Asynchronous reset in the middle of HOLD.
    pll_locked = 1'b1;
    repeat (11) tick();
    check("hold_not_ready", {31'd0, ready}, 32'd0);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_out_n", {31'd0, rst_out_n}, 32'd0);
    check("async_ready", {31'd0, ready}, 32'd0);
    check("async_pulse", {31'd0, lock_lost_pulse}, 32'd0);
    check("async_loss_count", {30'd0, loss_count}, 32'd0);
    @(posedge clock_in);
    #1;
    reset_n = 1'b1;
    run_lock("after_reset");
    check("after_reset_count", {30'd0, loss_count}, 32'd0);

`ifdef LOCK_TIMEOUT_EN
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    @(posedge clock_in);
    #1;
    reset_n = 1'b1;
    repeat (19) tick();
    check("timeout_before", {31'd0, pll_timeout}, 32'd0);
    tick();
    check("timeout_set", {31'd0, pll_timeout}, 32'd1);
    run_lock("timeout_lock");
    check("timeout_sticky", {31'd0, pll_timeout}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("timeout_cleared", {31'd0, pll_timeout}, 32'd0);
    reset_n = 1'b1;
`else
    check("timeout_tied_low", {31'd0, pll_timeout}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Consumes the PLL `locked` flag, running in the PLL output clock domain, and turns it into a clean, qualified, active-low reset for downstream logic (VGA timing core, pixel pipeline).
- Synchronises `locked`, requires it to stay high continuously for a programmable window, holds reset a further number of cycles, then releases.
- Detects lock loss, re-asserts reset immediately and counts loss events.

Parameters:
- SYNC_STAGES, 2: flops in the pll_locked synchroniser (≥2).
- STABLE_CYCLES, 1024: consecutive synchronised-high cycles required before leaving qualification (≥1).
- HOLD_CYCLES, 16: extra cycles reset stays asserted after qualification (≥1).
- LOSS_CNT_W, 8: width of the lock-loss counter.
- TIMEOUT_CYCLES, 65536: WAIT_LOCK timeout; used only with the optional feature.

Ports:
- clock_in  input  1  PLL output clock; sole clock.
- reset_n  input  1  asynchronous, active-low reset.
- pll_locked  input  1  raw PLL lock flag; asynchronous to clock_in.
- rst_out_n  output  1  downstream reset, active low, registered.
- ready  output  1  high iff state is RUN.
- lock_lost_pulse  output  1  one-cycle pulse on lock loss from RUN.
- loss_count  output  LOSS_CNT_W  saturating count of lock losses from RUN.
- pll_timeout  output  1  sticky timeout flag; tied 0 without LOCK_TIMEOUT_EN.

Behaviour:
- Reset: one clock, asynchronous active-low reset_n. While reset_n=0: state=WAIT_LOCK, synchroniser cleared, counters=0, rst_out_n=0, ready=0, lock_lost_pulse=0, loss_count=0, pll_timeout=0. Asserting reset_n mid-operation aborts any state immediately.
- lock_s is the synchroniser's last stage. All decisions use lock_s only.
- FSM:
  - WAIT_LOCK: cnt=0. lock_s=1 -> STABLE.
  - STABLE: cnt increments each cycle while lock_s=1. lock_s=1 with cnt==STABLE_CYCLES-1 -> HOLD, cnt=0. lock_s=0 -> WAIT_LOCK, cnt=0.
  - HOLD: cnt increments. cnt==HOLD_CYCLES-1 -> RUN. lock_s=0 -> WAIT_LOCK.
  - RUN: rst_out_n=1, ready=1. lock_s=0 -> WAIT_LOCK, pulse lock_lost_pulse, loss_count+1.
- rst_out_n and ready are registered from next-state:
  - Both rise on the edge that enters RUN.
  - Both fall on the edge that leaves RUN.
- Latency: with pll_locked held high, rst_out_n rises exactly SYNC_STAGES+STABLE_CYCLES+HOLD_CYCLES edges after the first edge sampling pll_locked=1 (that edge counts as 1).
- Lock drop: rst_out_n falls exactly SYNC_STAGES edges after the first edge sampling pll_locked=0.
- Glitch: any lock_s=0 in STABLE or HOLD restarts qualification from WAIT_LOCK. It does not pulse lock_lost_pulse or change loss_count; only losses from RUN count.
- loss_count saturates at 2^LOSS_CNT_W-1. lock_lost_pulse still pulses on a loss when saturated.
- Width: cnt is sized by $clog2 of max(STABLE_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES when enabled). It never wraps.

Optional Feature:
- Macro: LOCK_TIMEOUT_EN.
- Defined:
  - A separate timeout counter runs in WAIT_LOCK and STABLE, and clears on entering HOLD.
  - If it reaches TIMEOUT_CYCLES, pll_timeout sets and stays set until reset_n.
  - Sequencing is unaffected; qualification continues normally.
- Undefined: no timeout counter; pll_timeout is constant 0 and TIMEOUT_CYCLES is ignored.

Decomposition:
- Package pll_seq_pkg: state enum (WAIT_LOCK, STABLE, HOLD, RUN) and default parameter constants.
- One sub-module, lock_sync: a SYNC_STAGES-deep single-bit synchroniser with async active-low clear.

Test Plan:
Bench parameters: SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4, LOSS_CNT_W=2.
- Clean lock: pll_locked rises and stays high -> rst_out_n and ready rise exactly 14 edges after the first sampling edge; lock_lost_pulse never fires.
- Glitch during qualification: pll_locked high 5 cycles, low 1 cycle, then high -> loss_count stays 0; rst_out_n rises 14 edges after the second rise.
- Loss in RUN: drop pll_locked -> rst_out_n=0 after 2 edges; lock_lost_pulse high for exactly 1 cycle; loss_count=1; relock needs a full 14-edge sequence.
- Saturation: 5 loss/relock cycles -> loss_count=3 after the 3rd loss and stays 3; 5 pulses seen.
- Async reset: assert reset_n mid-HOLD between clock edges -> all outputs reset immediately; release with pll_locked high -> 14-edge sequence restarts.
- LOCK_TIMEOUT_EN, TIMEOUT_CYCLES=20, pll_locked held low -> pll_timeout=1 from cycle 20 onward; later lock still yields rst_out_n=1; pll_timeout stays 1 until reset_n.
